// File: rtl/sign_extender_pkg.sv
// sign_extender_pkg
// Shared constants for the LEGv8 decode-stage immediate generator:
// datapath widths, opcode values for every immediate-bearing instruction,
// the width of each immediate field, and the immediate-format enum.
// Ports: none (package).
`timescale 1ns/1ps
package sign_extender_pkg;

    localparam int INSTR_LEN = 32;
    localparam int WORD      = 64;

    // D-format: opcode in bits [31:21]
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    // CB-format: opcode in bits [31:24]
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
    // B-format: opcode in bits [31:26]
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [5:0]  OPC_BL   = 6'b100101;
    // I-format: opcode in bits [31:22]
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;

    // Immediate field widths
    localparam int D_IMM_W  = 9;
    localparam int CB_IMM_W = 19;
    localparam int B_IMM_W  = 26;
    localparam int I_IMM_W  = 12;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_D,
        IMM_CB,
        IMM_B,
        IMM_I
    } imm_fmt_t;

endpackage

// File: rtl/sign_extender_imm_format_decode.sv
// imm_format_decode
// Classifies an instruction by its top 11 opcode bits into the immediate
// format it carries. Checks are made in priority order D, CB, B, I; anything
// else (R-format, undefined) is IMM_NONE.
// Ports:
//   opcode - instruction[31:21]
//   fmt    - immediate format of the instruction
`timescale 1ns/1ps
module imm_format_decode
    import sign_extender_pkg::*;
(
    input  logic [10:0] opcode,
    output imm_fmt_t    fmt
);

    always_comb begin
        fmt = IMM_NONE;
        if (opcode == OPC_LDUR || opcode == OPC_STUR) begin
            fmt = IMM_D;
        end else if (opcode[10:3] == OPC_CBZ || opcode[10:3] == OPC_CBNZ) begin
            fmt = IMM_CB;
        end else if (opcode[10:5] == OPC_B || opcode[10:5] == OPC_BL) begin
            fmt = IMM_B;
        end else if (opcode[10:1] == OPC_ADDI || opcode[10:1] == OPC_SUBI) begin
            fmt = IMM_I;
        end
    end

endmodule

// File: rtl/sign_extender.sv
// sign_extender
// Decode-stage immediate generator. Extracts the immediate field of the
// instruction according to its format, sign-extends it (D, CB, B) or
// zero-extends it (I) to a full datapath word, and registers the result.
// Instructions without an immediate produce zero. Branch offsets are left
// as word counts; the shift-left-2 happens in the branch-target adder path.
// Ports:
//   clk                  - rising-edge clock
//   rst_n                - synchronous active-low reset, clears the output
//   instruction          - instruction word from IF/ID
//   sign_extended_output - extended immediate, valid one edge after input
`timescale 1ns/1ps
module sign_extender
    import sign_extender_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INSTR_LEN-1:0] instruction,
    output logic [WORD-1:0]      sign_extended_output
);

    imm_fmt_t        fmt;
    logic [WORD-1:0] imm_next;

    imm_format_decode u_decode (
        .opcode (instruction[31:21]),
        .fmt    (fmt)
    );

    // Field MSB is replicated into every upper bit for the signed formats.
    always_comb begin
        imm_next = '0;
        unique case (fmt)
            IMM_D:  imm_next = {{(WORD-D_IMM_W){instruction[20]}},  instruction[20:12]};
            IMM_CB: imm_next = {{(WORD-CB_IMM_W){instruction[23]}}, instruction[23:5]};
            IMM_B:  imm_next = {{(WORD-B_IMM_W){instruction[25]}},  instruction[25:0]};
            IMM_I:  imm_next = {{(WORD-I_IMM_W){1'b0}},             instruction[21:10]};
            default: imm_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_extended_output <= '0;
        end else begin
            sign_extended_output <= imm_next;
        end
    end

endmodule

// File: tb/tb_sign_extender.sv
`timescale 1ns/1ps
module tb_sign_extender;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [63:0] sign_extended_output;

    logic [63:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    sign_extender dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .instruction          (instruction),
        .sign_extended_output (sign_extended_output)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n       = 1'b0;
        instruction = 32'h0;
    end

    // ---------------- reference model ----------------
    // Immediate value computed arithmetically from the instruction fields.
    function automatic logic [63:0] ref_model(input logic [31:0] i);
        longint v;
        v = 0;
        if (i[31:21] == 11'h7C2 || i[31:21] == 11'h7C0) begin
            v = longint'(i[20:12]);
            if (v >= 256) v = v - 512;
        end else if (i[31:24] == 8'hB4 || i[31:24] == 8'hB5) begin
            v = longint'(i[23:5]);
            if (v >= 262144) v = v - 524288;
        end else if (i[31:26] == 6'h05 || i[31:26] == 6'h25) begin
            v = longint'(i[25:0]);
            if (v >= 33554432) v = v - 67108864;
        end else if (i[31:22] == 10'h244 || i[31:22] == 10'h344) begin
            v = longint'(i[21:10]);
        end
        return 64'(v);
    endfunction

    // ---------------- driver ----------------
    // Inputs change on the falling edge; the expected response for the
    // following rising edge is queued at the same time.
    task automatic drive(input logic rst, input logic [31:0] instr, input logic [63:0] exp);
        @(negedge clk);
        rst_n       = rst;
        instruction = instr;
        exp_q.push_back(exp);
    endtask

    task automatic drive_model(input logic [31:0] instr);
        drive(1'b1, instr, ref_model(instr));
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [63:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (sign_extended_output !== exp) begin
                    n_fail++;
                    $display("FAIL output: instr=%h got=%h expected=%h", instruction, sign_extended_output, exp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        n_checks = 0;
        n_fail   = 0;

        // Reset held for two edges with a B instruction present.
        drive(1'b0, 32'h14000040, 64'd0);
        drive(1'b0, 32'h14000040, 64'd0);
        drive(1'b1, 32'h14000040, 64'd64);

        // D-format
        drive(1'b1, 32'hF84402C9, 64'd96 - 64'd32);
        drive(1'b1, 32'hF80602CB, 64'd96);
        drive(1'b1, 32'hF85FF000, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b1, 32'hF8500000, 64'hFFFF_FFFF_FFFF_FF00);   // 0x100 -> -256
        drive(1'b1, 32'hF84FF000, 64'd255);
        // CB-format
        drive(1'b1, 32'hB4FFFF6B, 64'hFFFF_FFFF_FFFF_FFFB);   // -5
        drive(1'b1, 32'hB4000109, 64'd8);
        drive(1'b1, 32'hB5800000, 64'hFFFF_FFFF_FFFC_0000);   // -262144
        drive(1'b1, 32'hB57FFFE0, 64'd262143);
        // B-format
        drive(1'b1, 32'h14000040, 64'd64);
        drive(1'b1, 32'h17FFFFC9, 64'hFFFF_FFFF_FFFF_FFC9);   // -55
        drive(1'b1, 32'h95FFFFFF, 64'd33554431);
        drive(1'b1, 32'h16000000, 64'hFFFF_FFFF_FE00_0000);   // -33554432
        // R-format / other
        drive(1'b1, 32'h8B09026A, 64'd0);
        drive(1'b1, 32'hCB0A028B, 64'd0);
        drive(1'b1, 32'hAA150149, 64'd0);
        drive(1'b1, 32'h8A0A02C9, 64'd0);
        drive(1'b1, 32'h00000000, 64'd0);
        // I-format
        drive(1'b1, 32'h913FFC00, 64'd4095);
        drive(1'b1, 32'hD1000400, 64'd1);                     // SUBI #1
        drive(1'b1, 32'h913FFC00, 64'd4095);                  // I-format sign bit set, stays positive

        // Reset mid-stream discards the pending result.
        drive(1'b1, 32'hB4FFFF6B, 64'hFFFF_FFFF_FFFF_FFFB);
        drive(1'b0, 32'h17FFFFC9, 64'd0);
        drive(1'b1, 32'h17FFFFC9, 64'hFFFF_FFFF_FFFF_FFC9);

        // Randomized back-to-back stream biased toward immediate formats.
        for (int k = 0; k < 300; k++) begin
            r = $urandom;
            case ($urandom_range(0, 5))
                0: r[31:21] = ($urandom_range(0, 1) == 0) ? 11'h7C2 : 11'h7C0;
                1: r[31:24] = ($urandom_range(0, 1) == 0) ? 8'hB4 : 8'hB5;
                2: r[31:26] = ($urandom_range(0, 1) == 0) ? 6'h05 : 6'h25;
                3: r[31:22] = ($urandom_range(0, 1) == 0) ? 10'h244 : 10'h344;
                default: ;
            endcase
            if ($urandom_range(0, 49) == 0) begin
                drive(1'b0, r, 64'd0);
            end else begin
                drive_model(r);
            end
        end

        // Drain: every queued expectation must be consumed within a bound.
        repeat (4) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sign_extender.md
Name: sign_extender

Overview:
- Decode-stage immediate generator for the LEGv8/ARM single-cycle/pipelined datapath.
- Classifies the fetched 32-bit instruction by opcode and extracts its immediate field.
- Sign- or zero-extends the field to a 64-bit word and presents it, registered, to the ALU-B mux and to the branch-target adder.
- Non-immediate (R-format) and unrecognised instructions produce zero.

Parameters:
- INSTR_LEN, 32: instruction width in bits (from shared `INSTR_LEN`).
- WORD, 64: datapath word width in bits (from shared `WORD`).

Ports:
- clk, input, 1: system clock, rising-edge active.
- rst_n, input, 1: reset, synchronous, active-low.
- instruction, input, INSTR_LEN: instruction word from fetch/IF-ID.
- sign_extended_output, output, WORD: extended immediate, registered.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset: on a rising clk edge with rst_n=0, sign_extended_output <= 0. Reset has priority over any instruction. Reset asserted mid-stream discards the pending result; the first valid output appears one edge after rst_n returns high.
- Latency: exactly 1 cycle. The value computed from instruction at edge N is visible after edge N and held until the next edge.
- Combinational path: purely combinational decode + extend. No other state.
- Decode (first match, opcode fields per LEGv8):
  - D-format, bits[31:21] = 11111000010 (LDUR) or 11111000000 (STUR): field = instruction[20:12] (9-bit DT_address), sign-extended.
  - CB-format, bits[31:24] = 10110100 (CBZ) or 10110101 (CBNZ): field = instruction[23:5] (19 bits), sign-extended.
  - B-format, bits[31:26] = 000101 (B) or 100101 (BL): field = instruction[25:0] (26 bits), sign-extended.
  - I-format, bits[31:22] = 1001000100 (ADDI) or 1101000100 (SUBI): field = instruction[21:10] (12 bits), zero-extended.
  - All others, including R-format ADD/SUB/AND/ORR/LSL/LSR and undefined opcodes: output 0.
- Arithmetic: sign extension replicates the field MSB into all upper bits of WORD. No scaling: branch offsets are word counts, and the shift-left-2 is done downstream.
- Boundaries:
  - Most-negative field gives all-ones upper bits: D 0x100 -> -256; CB 0x40000 -> -262144; B 0x2000000 -> -33554432.
  - Most-positive field stays positive.
  - X/Z on instruction is not required to be handled.

Decomposition:
- Shared package (or the existing defines header): `INSTR_LEN`, `WORD`, and opcode constants (OPC_LDUR, OPC_STUR, OPC_CBZ, OPC_CBNZ, OPC_B, OPC_BL, OPC_ADDI, OPC_SUBI) with their field widths.
- Also in the package: enum imm_fmt_t {IMM_NONE, IMM_D, IMM_CB, IMM_B, IMM_I}.
- One natural sub-module: imm_format_decode (instruction -> imm_fmt_t). The extender body selects and extends based on it, then registers.

Test Plan:
- Reset: hold rst_n=0 with instruction=0x14000040 for 2 edges -> output 0. Release rst_n, one edge later -> 64.
- D-format:
  - LDUR X9,[X22,#64] (0xF84402C9) -> 64.
  - STUR X11,[X22,#96] (0xF80602CB) -> 96.
  - LDUR with imm9=0x1FF -> -1 (0xFFFF_FFFF_FFFF_FFFF).
- CB-format:
  - CBZ X11,-5 (0xB4FFFF6B) -> -5.
  - CBZ X9,8 (0xB4000109) -> 8.
  - CBNZ with imm19=0x40000 -> -262144.
- B-format:
  - B 64 (0x14000040) -> 64.
  - B -55 (0x17FFFFC9) -> -55.
  - BL with imm26=0x1FFFFFF -> 33554431.
- R-format/other, each 0:
  - ADD X10,X19,X9 (0x8B09026A)
  - SUB X11,X20,X10 (0xCB0A028B)
  - ORR X9,X10,X21 (0xAA150149)
  - AND X9,X22,X10 (0x8A0A02C9)
  - 0x00000000
- I-format and latency:
  - ADDI with imm12=0xFFF -> 4095 (zero-extended).
  - Back-to-back instructions on consecutive edges: each result appears exactly one edge after its input.
